// File: rtl/pwm_pkg.sv
// Shared types for the PWM fade sequencer.
// Command opcodes, channel states and default widths.
package pwm_pkg;

  localparam int DUTY_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_SET     = 2'b00,
    OP_FADE    = 2'b01,
    OP_BREATHE = 2'b10,
    OP_STOP    = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FADE,
    ST_BR_UP,
    ST_BR_DOWN
  } ch_state_t;

endpackage

// File: rtl/pwm_fade_sequencer_if.sv
// Command handshake bundle between control logic and the sequencer.
// Master drives commands; slave returns cmd_ready.
interface pwm_fade_sequencer_if
  import pwm_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DUTY_W = DUTY_W_DEF
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch;
  cmd_op_t           cmd_op;
  logic [DUTY_W-1:0] cmd_target;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_op,
    output cmd_target,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_op,
    input  cmd_target,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_fade_channel.sv
// One sequencer channel: set/fade/breathe/stop FSM driving a duty word.
// A load always wins over a step_tick arriving the same cycle.
module pwm_fade_channel
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_tick,
  input  logic              load,
  input  cmd_op_t           op,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  ch_state_t         state, state_n;
  logic [DUTY_W-1:0] duty_q, duty_n;
  logic [DUTY_W-1:0] goal_q, goal_n;
  logic              done_q, done_n;
  logic [DUTY_W-1:0] inc, dec;

  assign inc = duty_q + 1'b1;
  assign dec = duty_q - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      duty_q <= '0;
      goal_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      duty_q <= duty_n;
      goal_q <= goal_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = duty_q;
    goal_n  = goal_q;
    done_n  = 1'b0;
    if (load) begin
      unique case (op)
        OP_SET: begin
          duty_n  = target;
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
        OP_FADE: begin
          goal_n = target;
          if (target == duty_q) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_FADE;
          end
        end
        OP_BREATHE: begin
          goal_n  = target;
          state_n = (duty_q > target) ? ST_BR_DOWN : ST_BR_UP;
        end
        OP_STOP: state_n = ST_IDLE;
      endcase
    end else if (step_tick) begin
      unique case (state)
        ST_FADE: begin
          duty_n = (duty_q < goal_q) ? inc : dec;
          if (duty_n == goal_q) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
        ST_BR_UP: begin
          if (duty_q < goal_q) duty_n = inc;
          // peak 0 parks here rather than toggling direction
          if (duty_n == goal_q && goal_q != '0)
            state_n = ST_BR_DOWN;
        end
        ST_BR_DOWN: begin
          if (duty_q != '0) duty_n = dec;
          if (duty_n == '0) state_n = ST_BR_UP;
        end
        default: ;
      endcase
    end
  end

  assign duty = duty_q;
  assign busy = (state != ST_IDLE);
  assign done = done_q;

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Multi-channel fade sequencer feeding pwm_led_dimmer duty words.
// Holds the step prescaler, command decode and output packing.
module pwm_fade_sequencer
  import pwm_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int TICK_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  pwm_fade_sequencer_if.slave      cmd,
  output logic [N_CH*DUTY_W-1:0]   duty,
  output logic [N_CH-1:0]          busy,
  output logic [N_CH-1:0]          done
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW   = $clog2(TICK_DIV);

  logic [TW-1:0] cnt;
  logic          step_tick;
  logic          ready_q;
  logic          accept;

  assign step_tick = (cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || step_tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid & ready_q;

  // channel codes beyond N_CH match no load strobe and are dropped
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic load;
    assign load = accept && (cmd.cmd_ch == CH_W'(i));

    pwm_fade_channel #(
      .DUTY_W (DUTY_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .step_tick (step_tick),
      .load      (load),
      .op        (cmd.cmd_op),
      .target    (cmd.cmd_target),
      .duty      (duty[i*DUTY_W +: DUTY_W]),
      .busy      (busy[i]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed scenarios plus random
// commands, compared every cycle against a behavioural model.
module tb_pwm_fade_sequencer;
  import pwm_pkg::*;

  localparam int N_CH     = 4;
  localparam int DUTY_W   = 4;
  localparam int TICK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_fade_sequencer_if #(.N_CH(N_CH), .DUTY_W(DUTY_W)) cmd_bus ();

  logic [N_CH*DUTY_W-1:0] duty;
  logic [N_CH-1:0]        busy;
  logic [N_CH-1:0]        done;

  pwm_fade_sequencer #(
    .N_CH     (N_CH),
    .DUTY_W   (DUTY_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd_bus.slave),
    .duty (duty),
    .busy (busy),
    .done (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // model: mode 0 idle, 1 fading, 2 breathing; dir is breathe direction
  int m_duty [N_CH];
  int m_goal [N_CH];
  int m_mode [N_CH];
  int m_dir  [N_CH];
  int m_done [N_CH];
  int m_cnt;
  int m_ready;
  int m_max_br;

  function automatic void model_edge();
    bit tick;
    bit acc;
    int c;
    int tg;
    tick = (m_cnt == TICK_DIV - 1);
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        m_duty[i] = 0; m_goal[i] = 0; m_mode[i] = 0;
        m_dir[i] = 1; m_done[i] = 0;
      end
      m_cnt = 0;
      m_ready = 0;
      return;
    end
    m_cnt = (m_cnt + 1) % TICK_DIV;
    acc = cmd_bus.cmd_valid && (m_ready != 0);
    m_ready = 1;
    c  = int'(cmd_bus.cmd_ch);
    tg = int'(cmd_bus.cmd_target);
    for (int i = 0; i < N_CH; i++) begin
      m_done[i] = 0;
      if (acc && c == i) begin
        case (cmd_bus.cmd_op)
          OP_SET: begin
            m_duty[i] = tg; m_mode[i] = 0; m_done[i] = 1;
          end
          OP_FADE: begin
            m_goal[i] = tg;
            if (tg == m_duty[i]) begin
              m_mode[i] = 0; m_done[i] = 1;
            end else m_mode[i] = 1;
          end
          OP_BREATHE: begin
            m_goal[i] = tg; m_mode[i] = 2;
            m_dir[i] = (m_duty[i] > tg) ? -1 : 1;
          end
          default: m_mode[i] = 0;
        endcase
      end else if (tick) begin
        if (m_mode[i] == 1) begin
          m_duty[i] += (m_goal[i] > m_duty[i]) ? 1 : -1;
          if (m_duty[i] == m_goal[i]) begin
            m_mode[i] = 0; m_done[i] = 1;
          end
        end else if (m_mode[i] == 2) begin
          if (m_dir[i] > 0) begin
            if (m_duty[i] < m_goal[i]) m_duty[i]++;
            if (m_duty[i] == m_goal[i] && m_goal[i] != 0) m_dir[i] = -1;
          end else begin
            if (m_duty[i] > 0) m_duty[i]--;
            if (m_duty[i] == 0) m_dir[i] = 1;
          end
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("cmd_ready", 32'(cmd_bus.cmd_ready), 32'(m_ready));
    for (int i = 0; i < N_CH; i++) begin
      check($sformatf("duty%0d", i), 32'(duty[i*DUTY_W +: DUTY_W]), 32'(m_duty[i]));
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_mode[i] != 0));
      check($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (m_mode[2] == 2 && m_duty[2] > m_max_br) m_max_br = m_duty[2];
  endtask

  task automatic idle(int n);
    repeat (n) cycle();
  endtask

  task automatic send(int ch, cmd_op_t op, int tgt);
    cmd_bus.cmd_valid  = 1'b1;
    cmd_bus.cmd_ch     = 2'(ch);
    cmd_bus.cmd_op     = op;
    cmd_bus.cmd_target = 4'(tgt);
    cycle();
    cmd_bus.cmd_valid  = 1'b0;
  endtask

  int dn;

  initial begin
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_ch     = '0;
    cmd_bus.cmd_op     = OP_SET;
    cmd_bus.cmd_target = '0;
    m_max_br = 0;
    for (int i = 0; i < N_CH; i++) m_dir[i] = 1;
    m_cnt = 0;
    m_ready = 0;
    #1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // 1: reset mid-breathe
    send(2, OP_BREATHE, 5);
    idle(10);
    rst = 1'b1;
    idle(3);
    check("rst_duty2", 32'(duty[8 +: 4]), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cmd_bus.cmd_ready), 0);
    rst = 1'b0;
    cycle();
    check("ready_after_rst", 32'(cmd_bus.cmd_ready), 1);

    // 2: SET
    send(1, OP_SET, 9);
    check("set_duty1", 32'(duty[4 +: 4]), 9);
    check("set_done1", 32'(done[1]), 1);
    check("set_others", 32'({duty[0 +: 4], duty[8 +: 8]}), 0);

    // 3: FADE 0->5, count done pulses
    send(0, OP_FADE, 5);
    dn = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (done[0]) dn++;
    end
    check("fade0_duty", 32'(duty[0 +: 4]), 5);
    check("fade0_done_cnt", 32'(dn), 1);

    // 4: FADE 15->0 then equal-target FADE
    send(3, OP_SET, 15);
    send(3, OP_FADE, 0);
    idle(70);
    check("fade3_duty", 32'(duty[12 +: 4]), 0);
    send(3, OP_FADE, 0);
    check("fade3_eq_done", 32'(done[3]), 1);

    // 5: breathe peak 3, stop, breathe peak 0 from 7
    m_max_br = 0;
    send(2, OP_BREATHE, 3);
    idle(60);
    check("br_peak", 32'(m_max_br), 3);
    send(2, OP_STOP, 0);
    idle(10);
    send(2, OP_SET, 7);
    send(2, OP_BREATHE, 0);
    idle(40);
    check("br0_duty", 32'(duty[8 +: 4]), 0);
    check("br0_busy", 32'(busy[2]), 1);

    // 6: retarget mid-fade
    send(1, OP_SET, 0);
    send(1, OP_FADE, 15);
    for (int k = 0; k < 100 && m_duty[1] != 8; k++) cycle();
    check("retarget_at8", 32'(duty[4 +: 4]), 8);
    send(1, OP_FADE, 4);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (done[1]) dn++;
    end
    check("retarget_duty", 32'(duty[4 +: 4]), 4);
    check("retarget_done_cnt", 32'(dn), 1);

    // command landing on a step_tick: fade must not step that cycle
    send(0, OP_SET, 10);
    for (int k = 0; k < 8 && m_cnt != TICK_DIV - 1; k++) cycle();
    send(0, OP_FADE, 2);
    check("coincide_nostep", 32'(duty[0 +: 4]), 10);

    // random phase
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        idle($urandom_range(1, 3));
        rst = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        send($urandom_range(0, N_CH - 1), cmd_op_t'($urandom_range(0, 3)),
             $urandom_range(0, 15));
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
